wb_timer: RTL and testbench

Wishbone pipelined-mode responder providing a 32-bit prescaled timer/counter with compare match, overflow detection and a level interrupt. It hangs off a slave port of the peripheral crossbar, next to the boot ROM and GPIO, and answers CPU accesses that the crossbar has already routed and masked. Every accepted request receives exactly one registered `ack` or `err` one cycle later. Back-to-back pipelined requests are supported at one per cycle.

---
 rtl/wb_timer.sv | 95 +++++++++
 tb/tb_wb_timer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer.sv
// wb_timer: Wishbone pipelined responder with a prescaled 32-bit counter,
// compare match, overflow detection and a registered level interrupt.
module wb_timer #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int PS_W = 16
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   input  logic            wb_we_i,
   input  logic [AW-1:0]   wb_adr_i,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic [DW/8-1:0] wb_sel_i,
   output logic [DW-1:0]   wb_dat_o,
   output logic            wb_ack_o,
   output logic            wb_err_o,
   output logic            wb_stall_o,
   output logic            irq_o
);
   logic [3:0]      ctrl, ctrl_n;
   logic [PS_W-1:0] prescale, prescale_n, pc, pc_n;
   logic [31:0]     count, count_n, compare, compare_n, rd, mask, dat_q;
   logic [1:0]      status, status_n, clr;
   logic [2:0]      idx;
   logic            acc, mapped, wr, tick, match, ovf;
   logic            ack_q, err_q, stall_q, irq_q;
   logic            unused;

   assign idx    = wb_adr_i[4:2];
   assign unused = ^wb_adr_i[1:0];
   assign mapped = idx <= 3'd4;
   assign acc    = wb_cyc_i & wb_stb_i & ~stall_q;
   assign wr     = acc & wb_we_i;
   assign mask   = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

   assign tick  = ctrl[0] & (pc == prescale);
   assign match = tick & (count == compare);
   // An auto-reloading match on the all-ones value goes to 0 without counting as an overflow.
   assign ovf   = tick & (&count) & ~(match & ctrl[1]);

   assign rd = idx == 3'd0 ? {28'b0, ctrl} :
               idx == 3'd1 ? 32'(prescale) :
               idx == 3'd2 ? count :
               idx == 3'd3 ? compare :
               idx == 3'd4 ? {30'b0, status} : '0;

   always_comb begin
      ctrl_n     = wr && idx == 3'd0 ? (ctrl & ~mask[3:0]) | (wb_dat_i[3:0] & mask[3:0]) : ctrl;
      prescale_n = wr && idx == 3'd1 ? (prescale & ~mask[PS_W-1:0]) | (wb_dat_i[PS_W-1:0] & mask[PS_W-1:0]) : prescale;
      compare_n  = wr && idx == 3'd3 ? (compare & ~mask) | (wb_dat_i & mask) : compare;
      count_n    = wr && idx == 3'd2 ? (count & ~mask) | (wb_dat_i & mask) :
                   tick ? (match && ctrl[1] ? '0 : count + 32'd1) : count;
      pc_n       = wr && (idx == 3'd1 || idx == 3'd2) ? '0 :
                   tick ? '0 : ctrl[0] ? pc + 1'b1 : pc;
      clr        = wr && idx == 3'd4 && wb_sel_i[0] ? wb_dat_i[1:0] : 2'b00;
      status_n   = (status & ~clr) | {ovf, match};
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ctrl     <= '0;
         prescale <= '0;
         pc       <= '0;
         count    <= '0;
         compare  <= '1;
         status   <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= '0;
         irq_q    <= 1'b0;
         stall_q  <= 1'b1;
      end else begin
         ctrl     <= ctrl_n;
         prescale <= prescale_n;
         pc       <= pc_n;
         count    <= count_n;
         compare  <= compare_n;
         status   <= status_n;
         ack_q    <= acc & mapped;
         err_q    <= acc & ~mapped;
         dat_q    <= acc && !wb_we_i && mapped ? rd : '0;
         irq_q    <= (status[0] & ctrl[2]) | (status[1] & ctrl[3]);
         stall_q  <= 1'b0;
      end
   end

   // Dropping cyc during the response cycle aborts the pending termination.
   assign wb_ack_o   = ack_q & wb_cyc_i;
   assign wb_err_o   = err_q & wb_cyc_i;
   assign wb_dat_o   = wb_ack_o ? dat_q : '0;
   assign wb_stall_o = stall_q;
   assign irq_o      = irq_q;
endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: table vectors, directed timer sequences and random bus traffic
// checked cycle by cycle against a register-array reference model.
module tb_wb_timer;
   logic        clk = 0, rst = 1, cyc = 0, stb = 0, we = 0;
   logic [4:0]  adr = 0;
   logic [31:0] dat = 0;
   logic [3:0]  sel = 0;
   logic [31:0] dat_o;
   logic        ack, err, stall, irq;
   int          checks = 0, fails = 0;
   bit          mon_on = 0;

   wb_timer dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dat_o),
      .wb_ack_o(ack), .wb_err_o(err), .wb_stall_o(stall), .irq_o(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        ack;
      logic        err;
      logic [31:0] rd;
   } vec_t;

   // Reference model: registers as an array indexed by register number.
   logic [31:0] mr [5];
   logic [31:0] pc = 0, e_dat = 0;
   logic        e_ack = 0, e_err = 0, e_irq = 0, e_stall = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] keep(input logic [2:0] r);
      return r == 0 ? 32'hF : r == 1 ? 32'hFFFF : 32'hFFFF_FFFF;
   endfunction

   task automatic model_step();
      logic [2:0]  r;
      logic        acc, tick, ev_m, ev_o;
      logic [31:0] m;
      logic [32:0] nxt;
      if (rst) begin
         mr[0] = 0; mr[1] = 0; mr[2] = 0; mr[3] = 32'hFFFF_FFFF; mr[4] = 0;
         pc = 0; e_ack = 0; e_err = 0; e_dat = 0; e_irq = 0; e_stall = 1;
         return;
      end
      r = adr[4:2];
      acc = cyc && stb && !e_stall;
      e_ack = acc && r < 5;
      e_err = acc && r >= 5;
      e_dat = (acc && !we && r < 5) ? mr[r] : 32'h0;
      e_irq = |(mr[4][1:0] & mr[0][3:2]);
      tick = mr[0][0] && pc == mr[1];
      ev_m = tick && mr[2] == mr[3];
      ev_o = 0;
      if (mr[0][0]) pc = tick ? 0 : pc + 1;
      if (tick) begin
         nxt = {1'b0, mr[2]} + 33'd1;
         if (ev_m && mr[0][1]) nxt = 0;
         ev_o = nxt[32];
         mr[2] = nxt[31:0];
      end
      if (acc && we && r < 5) begin
         m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
         if (r == 4) mr[4] = mr[4] & ~(dat & m & 32'h3);
         else begin
            mr[r] = ((mr[r] & ~m) | (dat & m)) & keep(r);
            if (r == 1 || r == 2) pc = 0;
         end
      end
      mr[4] = mr[4] | {30'h0, ev_o, ev_m};
      e_stall = 0;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (mon_on) begin
         chk("mon_ack", 32'(ack), 32'(e_ack & cyc));
         chk("mon_err", 32'(err), 32'(e_err & cyc));
         chk("mon_dat", dat_o, (e_ack & cyc) ? e_dat : 32'h0);
         chk("mon_irq", 32'(irq), 32'(e_irq));
         chk("mon_stall", 32'(stall), 32'(e_stall));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Issued at negedge+1; accepted on the next posedge; response sampled at the following negedge.
   task automatic op(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rdat, output logic rack, output logic rerr);
      cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
      @(posedge clk);
      #1 stb = 0;
      @(negedge clk);
      rdat = dat_o; rack = ack; rerr = err;
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      logic [31:0] r;
      logic k, e;
      op(1'b1, a, d, 4'hF, r, k, e);
      chk("wr_ack", 32'(k), 32'd1);
   endtask

   task automatic rdc(input string n, input logic [4:0] a, input logic [31:0] x);
      logic [31:0] r;
      logic k, e;
      op(1'b0, a, 32'h0, 4'hF, r, k, e);
      chk(n, r, x);
   endtask

   initial begin
      vec_t        tbl [18];
      logic [31:0] r;
      logic        k, e;
      tbl[0]  = '{1'b0, 5'h0C, 32'h0,         4'hF, 1'b1, 1'b0, 32'hFFFF_FFFF};
      tbl[1]  = '{1'b0, 5'h00, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 5'h10, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
      tbl[3]  = '{1'b1, 5'h0C, 32'hAABB_CCDD, 4'hF, 1'b1, 1'b0, 32'h0};
      tbl[4]  = '{1'b1, 5'h0C, 32'h1122_3344, 4'h2, 1'b1, 1'b0, 32'h0};
      tbl[5]  = '{1'b0, 5'h0C, 32'h0,         4'hF, 1'b1, 1'b0, 32'hAABB_33DD};
      tbl[6]  = '{1'b0, 5'h18, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
      tbl[7]  = '{1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0};
      tbl[8]  = '{1'b0, 5'h0C, 32'h0,         4'hF, 1'b1, 1'b0, 32'hAABB_33DD};
      tbl[9]  = '{1'b1, 5'h04, 32'h0001_2345, 4'hF, 1'b1, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 5'h05, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0000_2345};
      tbl[11] = '{1'b1, 5'h00, 32'hFFFF_FFF0, 4'hF, 1'b1, 1'b0, 32'h0};
      tbl[12] = '{1'b0, 5'h00, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
      tbl[13] = '{1'b1, 5'h08, 32'hDEAD_BEEF, 4'h5, 1'b1, 1'b0, 32'h0};
      tbl[14] = '{1'b0, 5'h08, 32'h0,         4'hF, 1'b1, 1'b0, 32'h00AD_00EF};
      tbl[15] = '{1'b0, 5'h1C, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
      tbl[16] = '{1'b0, 5'h10, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
      tbl[17] = '{1'b1, 5'h10, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0};

      // Reset held for the posedges at 5, 15 and 25; released at 31.
      #6 mon_on = 1;
      @(negedge clk);
      chk("stall_in_rst", 32'(stall), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("stall_rst_end", 32'(stall), 32'd1);
      #1 rst = 0;
      #2 chk("stall_after_rel", 32'(stall), 32'd1);
      @(negedge clk);
      chk("stall_released", 32'(stall), 32'd0);
      #1;

      for (int i = 0; i < 18; i++) begin
         op(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, r, k, e);
         chk($sformatf("tbl%0d_ack", i), 32'(k), 32'(tbl[i].ack));
         chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].err));
         chk($sformatf("tbl%0d_dat", i), r, tbl[i].rd);
      end

      // Compare match with auto-reload: PRESCALE=3 gives one tick every 4 cycles.
      wr(5'h04, 32'd3);
      wr(5'h0C, 32'd4);
      wr(5'h08, 32'd0);
      wr(5'h00, 32'h7);
      for (int j = 1; j <= 24; j++) begin
         op(1'b0, 5'h08, 32'h0, 4'hF, r, k, e);
         chk($sformatf("match_cnt%0d", j), r, 32'(((j - 1) / 4) % 5));
         chk($sformatf("match_irq%0d", j), 32'(irq), 32'(j >= 21));
      end
      wr(5'h10, 32'h1);
      chk("match_irq_hold", 32'(irq), 32'd1);
      rdc("match_status_clr", 5'h10, 32'h0);
      chk("match_irq_fall", 32'(irq), 32'd0);
      wr(5'h00, 32'h0);

      // Overflow, and W1C colliding with a new overflow.
      wr(5'h10, 32'h3);
      wr(5'h04, 32'd0);
      wr(5'h0C, 32'd5);
      wr(5'h08, 32'hFFFF_FFFE);
      wr(5'h00, 32'h9);
      rdc("ovf_cnt_pre", 5'h08, 32'hFFFF_FFFE);
      rdc("ovf_cnt_max", 5'h08, 32'hFFFF_FFFF);
      rdc("ovf_cnt_wrap", 5'h08, 32'h0);
      rdc("ovf_status", 5'h10, 32'h2);
      wr(5'h08, 32'hFFFF_FFFF);
      wr(5'h10, 32'h2);
      rdc("ovf_set_wins", 5'h10, 32'h2);
      wr(5'h10, 32'h2);
      rdc("ovf_w1c", 5'h10, 32'h0);
      wr(5'h00, 32'h0);

      // Abort: cyc dropped in the response cycle; the write still lands.
      cyc = 1; stb = 1; we = 1; adr = 5'h08; dat = 32'h1234_5678; sel = 4'hF;
      @(posedge clk);
      #1 cyc = 0; stb = 0;
      @(negedge clk);
      chk("abort_ack", 32'(ack), 32'd0);
      chk("abort_err", 32'(err), 32'd0);
      #1 cyc = 1;
      rdc("abort_cnt", 5'h08, 32'h1234_5678);

      // Reset arriving while a read response is pending.
      cyc = 1; stb = 1; we = 0; adr = 5'h0C; sel = 4'hF;
      @(posedge clk);
      #1 stb = 0; rst = 1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_drop_ack", 32'(ack), 32'd0);
      chk("rst_stall", 32'(stall), 32'd1);
      @(negedge clk);
      #1 rst = 0;
      @(negedge clk);
      #1;
      rdc("rst_compare", 5'h0C, 32'hFFFF_FFFF);
      rdc("rst_ctrl", 5'h00, 32'h0);
      rdc("rst_count", 5'h08, 32'h0);

      // Random traffic, checked every cycle by the model.
      for (int n = 0; n < 3000; n++) begin
         int p, rr;
         p = $urandom_range(0, 99);
         rr = $urandom_range(0, 7);
         cyc = p >= 4;
         stb = p >= 4 && p < 70;
         we = $urandom_range(0, 1) == 1;
         adr = {3'(rr), 2'($urandom_range(0, 3))};
         sel = (p % 3 == 0) ? 4'($urandom) : 4'hF;
         dat = rr == 1 ? 32'($urandom_range(0, 3)) :
               (rr == 2 || rr == 3) ? ((p % 2 == 1) ? 32'($urandom_range(0, 9)) : 32'hFFFF_FFF6 + 32'($urandom_range(0, 9))) :
               32'($urandom);
         @(negedge clk);
         #1;
      end
      cyc = 0; stb = 0;
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
